// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU operation codes,
// FSM state codes, instruction fields, datapath select codes and the control word.
package multicycle_ctrl_pkg;

    localparam int ALUOP_W_DEF = 6;
    localparam int RA_REG      = 31;

    localparam logic [5:0] ALUOP_ADD  = 6'd0;
    localparam logic [5:0] ALUOP_ADDU = 6'd1;
    localparam logic [5:0] ALUOP_SUB  = 6'd2;
    localparam logic [5:0] ALUOP_SUBU = 6'd3;
    localparam logic [5:0] ALUOP_AND  = 6'd4;
    localparam logic [5:0] ALUOP_OR   = 6'd5;
    localparam logic [5:0] ALUOP_XOR  = 6'd6;
    localparam logic [5:0] ALUOP_NOR  = 6'd7;
    localparam logic [5:0] ALUOP_SLT  = 6'd8;
    localparam logic [5:0] ALUOP_SLTU = 6'd9;
    localparam logic [5:0] ALUOP_SLL  = 6'd10;
    localparam logic [5:0] ALUOP_SRL  = 6'd11;
    localparam logic [5:0] ALUOP_SRA  = 6'd12;
    localparam logic [5:0] ALUOP_SLLV = 6'd13;
    localparam logic [5:0] ALUOP_SRLV = 6'd14;
    localparam logic [5:0] ALUOP_SRAV = 6'd15;
    localparam logic [5:0] ALUOP_LUI  = 6'd16;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_REXEC  = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_IEXEC  = 4'd8;
    localparam logic [3:0] ST_IWB    = 4'd9;
    localparam logic [3:0] ST_BRANCH = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_JAL    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] ASRC_PC   = 2'd0;
    localparam logic [1:0] ASRC_REGA = 2'd1;
    localparam logic [1:0] ASRC_REGB = 2'd2;

    localparam logic [2:0] BSRC_REGB    = 3'd0;
    localparam logic [2:0] BSRC_FOUR    = 3'd1;
    localparam logic [2:0] BSRC_SIMM    = 3'd2;
    localparam logic [2:0] BSRC_SIMM_SH = 3'd3;
    localparam logic [2:0] BSRC_ZIMM    = 3'd4;
    localparam logic [2:0] BSRC_SHAMT   = 3'd5;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [1:0] pc_src;
        logic [5:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_write:   1'b0,
        iord:       1'b0,
        mem_write:  1'b0,
        ir_write:   1'b0,
        reg_dst:    2'd0,
        mem_to_reg: 2'd0,
        reg_write:  1'b0,
        alu_src_a:  2'd0,
        alu_src_b:  3'd0,
        pc_src:     2'd0,
        alu_op:     ALUOP_ADD,
        illegal:    1'b0
    };

    function automatic logic [5:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ADDIU: imm_alu_op = ALUOP_ADDU;
            OP_SLTI:  imm_alu_op = ALUOP_SLT;
            OP_SLTIU: imm_alu_op = ALUOP_SLTU;
            OP_ANDI:  imm_alu_op = ALUOP_AND;
            OP_ORI:   imm_alu_op = ALUOP_OR;
            OP_XORI:  imm_alu_op = ALUOP_XOR;
            OP_LUI:   imm_alu_op = ALUOP_LUI;
            default:  imm_alu_op = ALUOP_ADD;
        endcase
    endfunction

    // Logical immediates and lui take the zero-extended immediate.
    function automatic logic imm_is_zext(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: imm_is_zext = 1'b1;
            default:                          imm_is_zext = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational R-type Funct decoder: ALU operation, legality, and whether the
// operation shifts by the shamt field.
module alu_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [5:0] alu_op,
    output logic       legal,
    output logic       shamt_op
);

    // Funct lookup; unmapped codes are flagged illegal.
    always_comb begin
        alu_op   = ALUOP_ADD;
        legal    = 1'b1;
        shamt_op = 1'b0;
        case (funct)
            FN_SLL:  begin alu_op = ALUOP_SLL; shamt_op = 1'b1; end
            FN_SRL:  begin alu_op = ALUOP_SRL; shamt_op = 1'b1; end
            FN_SRA:  begin alu_op = ALUOP_SRA; shamt_op = 1'b1; end
            FN_SLLV: alu_op = ALUOP_SLLV;
            FN_SRLV: alu_op = ALUOP_SRLV;
            FN_SRAV: alu_op = ALUOP_SRAV;
            FN_ADD:  alu_op = ALUOP_ADD;
            FN_ADDU: alu_op = ALUOP_ADDU;
            FN_SUB:  alu_op = ALUOP_SUB;
            FN_SUBU: alu_op = ALUOP_SUBU;
            FN_AND:  alu_op = ALUOP_AND;
            FN_OR:   alu_op = ALUOP_OR;
            FN_XOR:  alu_op = ALUOP_XOR;
            FN_NOR:  alu_op = ALUOP_NOR;
            FN_SLT:  alu_op = ALUOP_SLT;
            FN_SLTU: alu_op = ALUOP_SLTU;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and drives the ALU operation and operand selects.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcA,
    output logic [2:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Illegal,
    output logic [3:0]         State
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [5:0] r_alu_op_s;
    logic       r_legal_s;
    logic       r_shamt_s;
    ctrl_t      ctrl_s;

    alu_decode u_alu_decode (
        .funct    (Funct),
        .alu_op   (r_alu_op_s),
        .legal    (r_legal_s),
        .shamt_op (r_shamt_s)
    );

    // Next-state and Moore control word.
    always_comb begin
        ctrl_s  = CTRL_IDLE;
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: begin
                ctrl_s.ir_write  = 1'b1;
                ctrl_s.alu_src_b = BSRC_FOUR;
                ctrl_s.pc_write  = 1'b1;
                state_d          = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl_s.alu_src_b = BSRC_SIMM_SH;
                case (Op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE: begin
                        if (r_legal_s) begin
                            state_d = ST_REXEC;
                        end else begin
                            ctrl_s.illegal = 1'b1;
                            state_d        = ST_FETCH;
                        end
                    end
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = ST_IEXEC;
                    OP_J:   state_d = ST_JUMP;
                    OP_JAL: state_d = ST_JAL;
                    default: begin
                        ctrl_s.illegal = 1'b1;
                        state_d        = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ctrl_s.alu_src_a = ASRC_REGA;
                ctrl_s.alu_src_b = BSRC_SIMM;
                if (Op == OP_LW) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                ctrl_s.iord = 1'b1;
                state_d     = ST_MEMWB;
            end
            ST_MEMWB: begin
                ctrl_s.reg_dst    = REGDST_RT;
                ctrl_s.mem_to_reg = M2R_MDR;
                ctrl_s.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_s.iord      = 1'b1;
                ctrl_s.mem_write = 1'b1;
            end
            ST_REXEC: begin
                ctrl_s.alu_op = r_alu_op_s;
                // Constant shifts shift regB by shamt rather than using regA.
                if (r_shamt_s) begin
                    ctrl_s.alu_src_a = ASRC_REGB;
                    ctrl_s.alu_src_b = BSRC_SHAMT;
                end else begin
                    ctrl_s.alu_src_a = ASRC_REGA;
                    ctrl_s.alu_src_b = BSRC_REGB;
                end
                state_d = ST_RWB;
            end
            ST_RWB: begin
                ctrl_s.reg_dst    = REGDST_RD;
                ctrl_s.mem_to_reg = M2R_ALUOUT;
                ctrl_s.reg_write  = 1'b1;
            end
            ST_IEXEC: begin
                ctrl_s.alu_src_a = ASRC_REGA;
                ctrl_s.alu_src_b = imm_is_zext(Op) ? BSRC_ZIMM : BSRC_SIMM;
                ctrl_s.alu_op    = imm_alu_op(Op);
                state_d          = ST_IWB;
            end
            ST_IWB: begin
                ctrl_s.reg_dst    = REGDST_RT;
                ctrl_s.mem_to_reg = M2R_ALUOUT;
                ctrl_s.reg_write  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_s.alu_src_a = ASRC_REGA;
                ctrl_s.alu_src_b = BSRC_REGB;
                ctrl_s.alu_op    = ALUOP_SUB;
                ctrl_s.pc_src    = PCSRC_ALUOUT;
                ctrl_s.pc_write  = (Op == OP_BNE) ? ~Zero : Zero;
            end
            ST_JUMP: begin
                ctrl_s.pc_src   = PCSRC_JUMP;
                ctrl_s.pc_write = 1'b1;
            end
            ST_JAL: begin
                // PC+4 is written to RA on the same edge the jump target loads.
                ctrl_s.pc_src     = PCSRC_JUMP;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.reg_dst    = REGDST_RA;
                ctrl_s.mem_to_reg = M2R_PC;
                ctrl_s.reg_write  = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // State register; reset forces FETCH asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Enables are masked while reset is held so nothing is written mid-reset.
    assign PCWrite  = ctrl_s.pc_write  & ~rst;
    assign IRWrite  = ctrl_s.ir_write  & ~rst;
    assign MemWrite = ctrl_s.mem_write & ~rst;
    assign RegWrite = ctrl_s.reg_write & ~rst;
    assign Illegal  = ctrl_s.illegal   & ~rst;
    assign IorD     = ctrl_s.iord;
    assign RegDst   = ctrl_s.reg_dst;
    assign MemtoReg = ctrl_s.mem_to_reg;
    assign ALUSrcA  = ctrl_s.alu_src_a;
    assign ALUSrcB  = ctrl_s.alu_src_b;
    assign PCSrc    = ctrl_s.pc_src;
    assign ALUOp    = ALUOP_W'(ctrl_s.alu_op);
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl, plus a mid-instruction reset sequence.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, PCSrc;
    logic [2:0] ALUSrcB;
    logic [5:0] ALUOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.ALUOP_W(6)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [3:0] st;
        logic       pcw;
        logic       iord;
        logic       memw;
        logic       irw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       rw;
        logic [1:0] asa;
        logic [2:0] asb;
        logic [1:0] pcs;
        logic [5:0] aop;
        logic       ill;
    } vec_t;

    vec_t vt[$];

    logic [26:0] act_s;
    always_comb act_s = {State, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                         RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp, Illegal};

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [3:0] st, input logic pcw, input logic iord,
                       input logic memw, input logic irw, input logic [1:0] rdst,
                       input logic [1:0] m2r, input logic rw, input logic [1:0] asa,
                       input logic [2:0] asb, input logic [1:0] pcs,
                       input logic [5:0] aop, input logic ill);
        vec_t v;
        v.op = op; v.funct = fn; v.zero = z; v.st = st; v.pcw = pcw; v.iord = iord;
        v.memw = memw; v.irw = irw; v.rdst = rdst; v.m2r = m2r; v.rw = rw;
        v.asa = asa; v.asb = asb; v.pcs = pcs; v.aop = aop; v.ill = ill;
        vt.push_back(v);
    endtask

    // FETCH then a legal DECODE: common to every instruction.
    task automatic add_fd(input logic [5:0] op, input logic [5:0] fn, input logic z);
        add(op, fn, z, ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, ALUOP_ADD, 1'b0);
        add(op, fn, z, ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd3, 2'd0, ALUOP_ADD, 1'b0);
    endtask

    task automatic add_branch(input logic [5:0] op, input logic z, input logic pcw);
        add_fd(op, 6'h00, z);
        add(op, 6'h00, z, ST_BRANCH, pcw, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd0, 2'd1, ALUOP_SUB, 1'b0);
    endtask

    task automatic add_illegal(input logic [5:0] op, input logic [5:0] fn);
        add(op, fn, 1'b0, ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, ALUOP_ADD, 1'b0);
        add(op, fn, 1'b0, ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd3, 2'd0, ALUOP_ADD, 1'b1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // lw: 5 cycles
        add_fd(6'h23, 6'h00, 1'b0);
        add(6'h23, 6'h00, 1'b0, ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, ALUOP_ADD, 1'b0);
        add(6'h23, 6'h00, 1'b0, ST_MEMRD,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        add(6'h23, 6'h00, 1'b0, ST_MEMWB,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        // sw: 4 cycles
        add_fd(6'h2B, 6'h00, 1'b0);
        add(6'h2B, 6'h00, 1'b0, ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, ALUOP_ADD, 1'b0);
        add(6'h2B, 6'h00, 1'b0, ST_MEMWR,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        // sll
        add_fd(6'h00, 6'h00, 1'b0);
        add(6'h00, 6'h00, 1'b0, ST_REXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd2, 3'd5, 2'd0, ALUOP_SLL, 1'b0);
        add(6'h00, 6'h00, 1'b0, ST_RWB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        // sub
        add_fd(6'h00, 6'h22, 1'b0);
        add(6'h00, 6'h22, 1'b0, ST_REXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd0, 2'd0, ALUOP_SUB, 1'b0);
        add(6'h00, 6'h22, 1'b0, ST_RWB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        // sra
        add_fd(6'h00, 6'h03, 1'b0);
        add(6'h00, 6'h03, 1'b0, ST_REXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd2, 3'd5, 2'd0, ALUOP_SRA, 1'b0);
        add(6'h00, 6'h03, 1'b0, ST_RWB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        // addi, ori, sltiu, lui
        add_fd(6'h08, 6'h00, 1'b0);
        add(6'h08, 6'h00, 1'b0, ST_IEXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, ALUOP_ADD, 1'b0);
        add(6'h08, 6'h00, 1'b0, ST_IWB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        add_fd(6'h0D, 6'h00, 1'b0);
        add(6'h0D, 6'h00, 1'b0, ST_IEXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd4, 2'd0, ALUOP_OR, 1'b0);
        add(6'h0D, 6'h00, 1'b0, ST_IWB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        add_fd(6'h0B, 6'h00, 1'b0);
        add(6'h0B, 6'h00, 1'b0, ST_IEXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd2, 2'd0, ALUOP_SLTU, 1'b0);
        add(6'h0B, 6'h00, 1'b0, ST_IWB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        add_fd(6'h0F, 6'h00, 1'b0);
        add(6'h0F, 6'h00, 1'b0, ST_IEXEC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd4, 2'd0, ALUOP_LUI, 1'b0);
        add(6'h0F, 6'h00, 1'b0, ST_IWB,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd0, 2'd0, ALUOP_ADD, 1'b0);
        // beq / bne with both Zero values
        add_branch(6'h04, 1'b1, 1'b1);
        add_branch(6'h04, 1'b0, 1'b0);
        add_branch(6'h05, 1'b1, 1'b0);
        add_branch(6'h05, 1'b0, 1'b1);
        // j, jal
        add_fd(6'h02, 6'h00, 1'b0);
        add(6'h02, 6'h00, 1'b0, ST_JUMP, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd2, ALUOP_ADD, 1'b0);
        add_fd(6'h03, 6'h00, 1'b0);
        add(6'h03, 6'h00, 1'b0, ST_JAL,  1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 2'd0, 3'd0, 2'd2, ALUOP_ADD, 1'b0);
        // illegal Op, illegal Funct; the pulse must not persist into the next FETCH
        add_illegal(6'h3F, 6'h00);
        add_illegal(6'h00, 6'h3F);
        add(6'h23, 6'h00, 1'b0, ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd1, 2'd0, ALUOP_ADD, 1'b0);

        Op = 6'h00; Funct = 6'h00; Zero = 1'b0; rst = 1'b1;
        #2;
        check("reset_state", 32'(State), 32'(ST_FETCH));
        check("reset_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            Op = vt[i].op; Funct = vt[i].funct; Zero = vt[i].zero;
            #1;
            check($sformatf("row%0d_op%h_st%0d", i, vt[i].op, vt[i].st), 32'(act_s),
                  32'({vt[i].st, vt[i].pcw, vt[i].iord, vt[i].memw, vt[i].irw, vt[i].rdst,
                       vt[i].m2r, vt[i].rw, vt[i].asa, vt[i].asb, vt[i].pcs, vt[i].aop,
                       vt[i].ill}));
            @(negedge clk);
        end

        // The last row left a lw in DECODE; walk it to MEMRD and reset there.
        Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_pre_state", 32'(State), 32'(ST_MEMRD));
        rst = 1'b1;
        #1;
        check("midrst_async_state", 32'(State), 32'(ST_FETCH));
        check("midrst_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        @(negedge clk);
        check("midrst_hold_state", 32'(State), 32'(ST_FETCH));
        check("midrst_hold_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_fetch", 32'({State, IRWrite, PCWrite, ALUOp}),
              32'({ST_FETCH, 1'b1, 1'b1, ALUOP_ADD}));
        @(negedge clk);
        check("post_rst_decode", 32'(State), 32'(ST_DECODE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
